muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV64M instructions: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus the word forms MULW/DIVW/DIVUW/REMW/REMUW.
- Sits beside the execute stage of the core. The core hands over an M-class instruction when decode gives opcode 0110011/0111011 with func7=0000001.
- The block runs a radix-2 shift-add multiply or restoring divide, one bit per cycle. The core is held stalled via busy until the result is returned.

---
 rtl/muldiv_seq_pkg.sv | 50 +++++
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/muldiv_seq_iter.sv | 41 ++++
 rtl/muldiv_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg -- shared types and helpers for the RV64M multiply/divide sequencer.
//   muldiv_op_t    : func3 encodings of the M-extension ops
//   muldiv_state_t : sequencer states
//   OPC_* / F7_*   : decode constants identifying an M-class instruction
//   op_src*_signed : which operands an op treats as two's complement
package muldiv_seq_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OP32  = 7'b0111011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } muldiv_state_t;

   // rs1 is signed for every signed op, including MULHSU
   function automatic logic op_src1_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b110: s = 1'b1;
         default:                                s = 1'b0;
      endcase
      return s;
   endfunction

   // rs2 is signed for MUL/MULH/DIV/REM only
   function automatic logic op_src2_signed(input logic [2:0] f3);
      logic s;
      case (f3)
         3'b000, 3'b001, 3'b100, 3'b110: s = 1'b1;
         default:                        s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- request/response bundle between the core and muldiv_seq.
//   master (core)  : drives req_valid/req_func3/req_word/req_src1/req_src2/flush,
//                    observes req_ready/busy/resp_valid/resp_data
//   slave (block)  : the reverse
interface muldiv_seq_if #(parameter int XLEN = 64);

   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_func3;
   logic            req_word;
   logic [XLEN-1:0] req_src1;
   logic [XLEN-1:0] req_src2;
   logic            flush;
   logic            busy;
   logic            resp_valid;
   logic [XLEN-1:0] resp_data;

   modport master (
      output req_valid, req_func3, req_word, req_src1, req_src2, flush,
      input  req_ready, busy, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_func3, req_word, req_src1, req_src2, flush,
      output req_ready, busy, resp_valid, resp_data
   );

endinterface

// File: rtl/muldiv_seq_iter.sv
// muldiv_iter -- one combinational step of the radix-2 multiply / restoring divide.
//   is_div   : 1 = divide step, 0 = multiply step
//   acc      : 2*XLEN working register
//              multiply: {partial product high, multiplier remaining}
//              divide  : {partial remainder, dividend bits / quotient bits}
//   operand  : multiplicand (multiply) or divisor (divide) magnitude
//   acc_next : accumulator after this step
module muldiv_iter #(
   parameter int XLEN = 64
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   operand,
   output logic [2*XLEN-1:0] acc_next
);

   logic [XLEN:0]   sum_s;
   logic [XLEN:0]   rem_sh_s;
   logic [XLEN-1:0] diff_s;
   logic            ok_s;

   // single add-shift or compare-subtract-shift step
   always_comb begin
      sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      // remainder shifted left by one with the next dividend bit brought in
      rem_sh_s = acc[2*XLEN-1:XLEN-1];
      ok_s     = (rem_sh_s >= {1'b0, operand});
      // when the subtract succeeds the difference is below the divisor, so XLEN bits suffice
      diff_s   = rem_sh_s[XLEN-1:0] - operand;
      if (is_div) begin
         if (ok_s) begin
            acc_next = {diff_s, acc[XLEN-2:0], 1'b1};
         end else begin
            acc_next = {rem_sh_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_next = {sum_s, acc[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq -- multi-cycle RV64M multiply/divide sequencer (one bit per cycle).
//   clk    : core clock
//   resetn : asynchronous active-low reset
//   bus    : muldiv_seq_if.slave -- request (valid/ready, func3, word, src1, src2),
//            flush, busy stall, single-cycle resp_valid with held resp_data
// Flow: IDLE -accept-> CALC (N cycles) -> FIX -> DONE -> IDLE; divide by zero,
// signed overflow and multiply by zero go IDLE -> FIX directly.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic         clk,
   input  logic         resetn,
   muldiv_seq_if.slave  bus
);

   localparam int              HALF = XLEN / 2;
   localparam int              CW   = $clog2(XLEN);
   localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
   localparam logic [CW-1:0]   LAST_X = CW'(XLEN - 1);
   localparam logic [CW-1:0]   LAST_W = CW'(HALF - 1);

   muldiv_state_t     state_r;
   muldiv_op_t        op_r;
   logic              div_r;
   logic              word_r;
   logic              neg1_r;
   logic              neg2_r;
   logic              fast_r;
   logic [CW-1:0]     cnt_r;
   logic [2*XLEN-1:0] acc_r;
   logic [XLEN-1:0]   opnd_r;
   logic              req_ready_r;
   logic              busy_r;
   logic              resp_valid_r;
   logic [XLEN-1:0]   resp_data_r;

   logic              sgn1_s, sgn2_s, is_div_s;
   logic [XLEN-1:0]   ext1_s, ext2_s, mag1_s, mag2_s, most_neg_s;
   logic              neg1_s, neg2_s;
   logic              div0_s, ovf_s, mul0_s, fast_s;
   logic [XLEN-1:0]   fast_res_s;
   logic [2*XLEN-1:0] acc_init_s;
   logic [XLEN-1:0]   opnd_init_s;
   logic [2*XLEN-1:0] acc_next_s;
   logic [2*XLEN-1:0] prod_s, prod_fix_s;
   logic [XLEN-1:0]   quot_s, rem_s, sel_s, raw_s, fix_s;
   logic [CW-1:0]     last_s;

   assign bus.req_ready  = req_ready_r;
   assign bus.busy       = busy_r;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_data  = resp_data_r;

   // operand preparation at accept: W extension, magnitudes, fast-path detection
   always_comb begin
      sgn1_s   = op_src1_signed(bus.req_func3);
      sgn2_s   = op_src2_signed(bus.req_func3);
      is_div_s = bus.req_func3[2];
      if (bus.req_word) begin
         ext1_s     = {{HALF{sgn1_s & bus.req_src1[HALF-1]}}, bus.req_src1[HALF-1:0]};
         ext2_s     = {{HALF{sgn2_s & bus.req_src2[HALF-1]}}, bus.req_src2[HALF-1:0]};
         most_neg_s = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      end else begin
         ext1_s     = bus.req_src1;
         ext2_s     = bus.req_src2;
         most_neg_s = {1'b1, {(XLEN-1){1'b0}}};
      end
      neg1_s = sgn1_s & ext1_s[XLEN-1];
      neg2_s = sgn2_s & ext2_s[XLEN-1];
      if (neg1_s) begin
         mag1_s = ZERO - ext1_s;
      end else begin
         mag1_s = ext1_s;
      end
      if (neg2_s) begin
         mag2_s = ZERO - ext2_s;
      end else begin
         mag2_s = ext2_s;
      end
      div0_s = is_div_s & (ext2_s == ZERO);
      ovf_s  = is_div_s & sgn1_s & (ext1_s == most_neg_s) & (ext2_s == ONES);
      mul0_s = ~is_div_s & ((ext1_s == ZERO) | (ext2_s == ZERO));
      fast_s = div0_s | ovf_s | mul0_s;
      // func3[1] distinguishes remainder from quotient on the divide side
      if (div0_s) begin
         if (bus.req_func3[1]) begin
            fast_res_s = ext1_s;
         end else begin
            fast_res_s = ONES;
         end
      end else if (ovf_s) begin
         if (bus.req_func3[1]) begin
            fast_res_s = ZERO;
         end else begin
            fast_res_s = most_neg_s;
         end
      end else begin
         fast_res_s = ZERO;
      end
      // fast results ride in the low accumulator half straight to FIX
      if (fast_s) begin
         acc_init_s = {ZERO, fast_res_s};
      end else if (is_div_s) begin
         if (bus.req_word) begin
            // left-align the 32-bit dividend so its MSB enters the remainder first
            acc_init_s = {ZERO, mag1_s[HALF-1:0], {HALF{1'b0}}};
         end else begin
            acc_init_s = {ZERO, mag1_s};
         end
      end else begin
         acc_init_s = {ZERO, mag2_s};
      end
      if (is_div_s) begin
         opnd_init_s = mag2_s;
      end else begin
         opnd_init_s = mag1_s;
      end
   end

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .is_div   (div_r),
      .acc      (acc_r),
      .operand  (opnd_r),
      .acc_next (acc_next_s)
   );

   // sign fix-up, result selection and W-form sign extension
   always_comb begin
      // after 32 W steps the product sits 32 bits above the LSB
      if (word_r) begin
         prod_s = {{HALF{1'b0}}, acc_r[2*XLEN-1:HALF]};
      end else begin
         prod_s = acc_r;
      end
      if (neg1_r ^ neg2_r) begin
         prod_fix_s = {(2*XLEN){1'b0}} - prod_s;
         quot_s     = ZERO - acc_r[XLEN-1:0];
      end else begin
         prod_fix_s = prod_s;
         quot_s     = acc_r[XLEN-1:0];
      end
      if (neg1_r) begin
         rem_s = ZERO - acc_r[2*XLEN-1:XLEN];
      end else begin
         rem_s = acc_r[2*XLEN-1:XLEN];
      end
      case (op_r)
         OP_MUL:                       sel_s = prod_fix_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: sel_s = prod_fix_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              sel_s = quot_s;
         OP_REM, OP_REMU:              sel_s = rem_s;
         default:                      sel_s = ZERO;
      endcase
      if (fast_r) begin
         raw_s = acc_r[XLEN-1:0];
      end else begin
         raw_s = sel_s;
      end
      if (word_r) begin
         fix_s = {{HALF{raw_s[HALF-1]}}, raw_s[HALF-1:0]};
      end else begin
         fix_s = raw_s;
      end
      if (word_r) begin
         last_s = LAST_W;
      end else begin
         last_s = LAST_X;
      end
   end

   // sequencer FSM with registered handshake and response outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IDLE;
         op_r         <= OP_MUL;
         div_r        <= 1'b0;
         word_r       <= 1'b0;
         neg1_r       <= 1'b0;
         neg2_r       <= 1'b0;
         fast_r       <= 1'b0;
         cnt_r        <= {CW{1'b0}};
         acc_r        <= {(2*XLEN){1'b0}};
         opnd_r       <= ZERO;
         req_ready_r  <= 1'b1;
         busy_r       <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_data_r  <= ZERO;
      end else begin
         resp_valid_r <= 1'b0;
         if (bus.flush) begin
            // abort wins over everything, including a request arriving in IDLE
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
         end else begin
            case (state_r)
               IDLE: begin
                  if (bus.req_valid) begin
                     op_r        <= muldiv_op_t'(bus.req_func3);
                     div_r       <= is_div_s;
                     word_r      <= bus.req_word;
                     neg1_r      <= neg1_s;
                     neg2_r      <= neg2_s;
                     fast_r      <= fast_s;
                     cnt_r       <= {CW{1'b0}};
                     acc_r       <= acc_init_s;
                     opnd_r      <= opnd_init_s;
                     busy_r      <= 1'b1;
                     req_ready_r <= 1'b0;
                     state_r     <= fast_s ? FIX : CALC;
                  end
               end
               CALC: begin
                  acc_r <= acc_next_s;
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  if (cnt_r == last_s) begin
                     state_r <= FIX;
                  end
               end
               FIX: begin
                  resp_data_r  <= fix_s;
                  resp_valid_r <= 1'b1;
                  busy_r       <= 1'b0;
                  state_r      <= DONE;
               end
               DONE: begin
                  req_ready_r <= 1'b1;
                  state_r     <= IDLE;
               end
               default: begin
                  state_r     <= IDLE;
                  busy_r      <= 1'b0;
                  req_ready_r <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- self-checking bench for muldiv_seq: directed cases, random ops
// against an arithmetic reference model, flush and mid-operation reset.
module tb_muldiv_seq;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_fails  = 0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.XLEN(64)) bus ();

   muldiv_seq #(.XLEN(64)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // reference result computed directly from the RV64M definitions
   function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic [127:0] x, y, p;
      logic [31:0]  r32, ua, ub;
      int           sa, sb;
      longint       la, lb;
      logic [63:0]  r;
      if (w) begin
         ua = a[31:0];
         ub = b[31:0];
         sa = $signed(a[31:0]);
         sb = $signed(b[31:0]);
         case (f3)
            3'b100:  r32 = (ub == 0) ? 32'hFFFFFFFF :
                           (ua == 32'h80000000 && sb == -1) ? 32'h80000000 : 32'(sa / sb);
            3'b101:  r32 = (ub == 0) ? 32'hFFFFFFFF : ua / ub;
            3'b110:  r32 = (ub == 0) ? ua :
                           (ua == 32'h80000000 && sb == -1) ? 32'h0 : 32'(sa % sb);
            3'b111:  r32 = (ub == 0) ? ua : ua % ub;
            default: r32 = ua * ub;
         endcase
         return {{32{r32[31]}}, r32};
      end
      la = $signed(a);
      lb = $signed(b);
      case (f3)
         3'b000: r = a * b;
         3'b001: begin x = {{64{a[63]}}, a}; y = {{64{b[63]}}, b}; p = x * y; r = p[127:64]; end
         3'b010: begin x = {{64{a[63]}}, a}; y = {64'h0, b};       p = x * y; r = p[127:64]; end
         3'b011: begin x = {64'h0, a};       y = {64'h0, b};       p = x * y; r = p[127:64]; end
         3'b100: r = (b == 0) ? 64'hFFFFFFFFFFFFFFFF :
                     (a == 64'h8000000000000000 && lb == -1) ? a : 64'(la / lb);
         3'b101: r = (b == 0) ? 64'hFFFFFFFFFFFFFFFF : a / b;
         3'b110: r = (b == 0) ? a :
                     (a == 64'h8000000000000000 && lb == -1) ? 64'h0 : 64'(la % lb);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // cycles from accept to resp_valid
   function automatic int ref_latency(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
      logic az, bz, ovf;
      az  = w ? (a[31:0] == 32'h0) : (a == 64'h0);
      bz  = w ? (b[31:0] == 32'h0) : (b == 64'h0);
      ovf = (f3 == 3'b100 || f3 == 3'b110) &&
            (w ? (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF)
               : (a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF));
      if (f3[2] ? (bz || ovf) : (az || bz)) return 2;
      return w ? 34 : 66;
   endfunction

   // issue one op, follow it to its response and check result, timing and handshake
   task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input bit hold, input string tag);
      logic [63:0] exp_data, got_data;
      int          exp_lat, got_lat;
      logic        busy_ok, ready_ok, busy_at_resp;
      exp_data = ref_result(f3, w, a, b);
      exp_lat  = ref_latency(f3, w, a, b);
      got_data = 64'hx;
      got_lat  = 0;
      busy_ok  = 1'b1;
      ready_ok = 1'b1;
      busy_at_resp = 1'bx;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_func3 = f3;
      bus.req_word  = w;
      bus.req_src1  = a;
      bus.req_src2  = b;
      @(posedge clk);
      #1;
      // operands must already be latched; scramble them, optionally keep valid up
      bus.req_valid = hold;
      bus.req_src1  = {$urandom, $urandom};
      bus.req_src2  = {$urandom, $urandom};
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (bus.resp_valid === 1'b1) begin
            got_lat      = k;
            got_data     = bus.resp_data;
            busy_at_resp = bus.busy;
            break;
         end
         if (bus.busy !== 1'b1)      busy_ok  = 1'b0;
         if (bus.req_ready !== 1'b0) ready_ok = 1'b0;
      end
      bus.req_valid = 1'b0;
      check({tag, " data"},      got_data, exp_data);
      check({tag, " latency"},   64'(got_lat), 64'(exp_lat));
      check({tag, " busy held"}, {63'h0, busy_ok & ready_ok}, 64'h1);
      check({tag, " busy at resp"}, {63'h0, busy_at_resp}, 64'h0);
      @(posedge clk);
      #1;
      check({tag, " ready after"}, {62'h0, bus.req_ready, bus.resp_valid}, 64'h2);
   endtask

   function automatic logic [63:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return 64'h0;
         1:       return 64'hFFFFFFFFFFFFFFFF;
         2:       return 64'h8000000000000000;
         3:       return 64'hFFFFFFFF80000000;
         4:       return 64'($urandom_range(1, 20));
         5:       return 64'h0 - 64'($urandom_range(1, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a, b;
      logic        seen;

      resetn        = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_func3 = 3'b000;
      bus.req_word  = 1'b0;
      bus.req_src1  = 64'h0;
      bus.req_src2  = 64'h0;
      bus.flush     = 1'b0;
      #12;
      check("reset outputs", {60'h0, bus.req_ready, bus.busy, bus.resp_valid, 1'b0}, 64'h8);
      check("reset data", bus.resp_data, 64'h0);
      @(negedge clk);
      resetn = 1'b1;

      run_op(3'b000, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 1'b0, "MUL 7*-3");
      check("MUL 7*-3 const", bus.resp_data, 64'hFFFFFFFFFFFFFFEB);
      run_op(3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, "MULHU max");
      check("MULHU const", bus.resp_data, 64'hFFFFFFFFFFFFFFFE);
      run_op(3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 1'b0, "MULHSU -1*2");
      run_op(3'b001, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 1'b0, "MULH minneg^2");
      run_op(3'b100, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b0, "DIV -7/2");
      check("DIV const", bus.resp_data, 64'hFFFFFFFFFFFFFFFD);
      run_op(3'b110, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 1'b0, "REM -7/2");
      run_op(3'b100, 1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, "DIVW ovf");
      check("DIVW const", bus.resp_data, 64'hFFFFFFFF80000000);
      run_op(3'b111, 1'b1, 64'd5, 64'h0, 1'b0, "REMUW 5/0");
      run_op(3'b101, 1'b0, 64'h123456789ABCDEF0, 64'h0, 1'b0, "DIVU x/0");
      run_op(3'b000, 1'b1, 64'h00000000FFFFFFFF, 64'h0000000000000003, 1'b0, "MULW -1*3");
      run_op(3'b101, 1'b1, 64'hAAAA0000FFFFFFF0, 64'h0000000000000003, 1'b0, "DIVUW");
      run_op(3'b110, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, "REM ovf");

      for (int i = 0; i < 30; i++) begin
         f3 = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         if (w && f3 != 3'b000 && !f3[2]) f3 = 3'b000;
         a  = rand_opnd();
         b  = rand_opnd();
         run_op(f3, w, a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d f3=%0d w=%0d", i, f3, w));
      end

      // flush at CALC iteration 10
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_func3 = 3'b000;
      bus.req_word  = 1'b0;
      bus.req_src1  = 64'd1000;
      bus.req_src2  = 64'd77;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush next cycle", {61'h0, bus.req_ready, bus.busy, bus.resp_valid}, 64'h4);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid === 1'b1) seen = 1'b1;
      end
      check("flush no resp", {63'h0, seen}, 64'h0);
      run_op(3'b000, 1'b0, 64'd3, 64'd4, 1'b0, "MUL 3*4 after flush");
      check("MUL 3*4 const", bus.resp_data, 64'd12);

      // flush together with a request in IDLE: nothing accepted
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      bus.req_src1  = 64'd9;
      bus.req_src2  = 64'd9;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      check("flush beats req", {63'h0, seen}, 64'h0);

      // reset mid-CALC
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_func3 = 3'b100;
      bus.req_word  = 1'b0;
      bus.req_src1  = 64'd123456789;
      bus.req_src2  = 64'd1000;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("mid reset outputs", {61'h0, bus.req_ready, bus.busy, bus.resp_valid}, 64'h4);
      check("mid reset data", bus.resp_data, 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (bus.resp_valid === 1'b1) seen = 1'b1;
      end
      check("reset no resp", {63'h0, seen}, 64'h0);
      run_op(3'b111, 1'b0, 64'd100, 64'd7, 1'b0, "REMU after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
